sram_host_ctrl: RTL and testbench
=================================

SRAM_HOST_CTRL -- requirements
Module: sram_host_ctrl

Interface
REQ-001 The block SHALL have the parameter ROWS, default 16, giving the number of SRAM words.
REQ-002 The block SHALL have the parameter COLS, default 8, giving the SRAM word width in bits.
REQ-003 The block SHALL have the parameter TIMEOUT_CYC, default 16, giving the read timeout in cycles.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset:
  clk  in  1  clock; all state changes on its rising edge.
  arst_n  in  1  asynchronous active-low reset.
REQ-005 The host-side ports SHALL be:
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when high with req_valid.
  req_we  in  1  1 = write, 0 = read.
  req_addr  in  $clog2(ROWS)  word address.
  req_wdata  in  COLS  write data.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  response consumed when high with rsp_valid.
  rsp_data  out  COLS  read data; 0 for writes.
  rsp_err  out  1  read timed out.
REQ-006 The SRAM-side ports SHALL be:
  serial_in  out  1  serial write bit.
  shift  out  1  SIPO shift strobe.
  load  out  1  SIPO-to-latch transfer strobe.
  w_en  out  1  write strobe.
  r_en  out  1  read request.
  addr  out  $clog2(ROWS)  SRAM address.
  data_valid  in  1  read data valid.
  data_out  in  COLS  read data.

Function
REQ-007 The FSM SHALL have the states IDLE, SHIFT, LOAD, WRITE, READ and RESP.
REQ-008 req_ready SHALL be 1 only in IDLE.
REQ-009 On acceptance, the block SHALL register req_addr, req_we and req_wdata, and SHALL drive addr from the registered address until it returns to IDLE.
REQ-010 On acceptance of a write, the block SHALL go to SHIFT.
REQ-011 On acceptance of a read, the block SHALL go to READ.
REQ-012 In SHIFT, the block SHALL hold shift=1 for exactly COLS consecutive cycles, with serial_in driven MSB first (bit COLS-1 in the first cycle, bit 0 in the last), using a bit counter of width $clog2(COLS)+1.
REQ-013 In LOAD, the block SHALL assert load=1 for exactly one cycle with shift=0.
REQ-014 In WRITE, the block SHALL assert w_en=1 for exactly one cycle and then go to RESP.
REQ-015 A write SHALL issue its first shift one cycle after acceptance, and rsp_valid SHALL rise COLS+3 cycles after acceptance.
REQ-016 In READ, the block SHALL hold r_en=1.
REQ-017 The first cycle in READ with data_valid=1 SHALL capture data_out into rsp_data, drop r_en on the next cycle and go to RESP.
REQ-018 In RESP, rsp_valid SHALL be 1 and the block SHALL hold rsp_data and rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-019 A response accepted in cycle N SHALL allow a new request to be accepted no earlier than cycle N+1.
REQ-020 The strobes shift, load, w_en and r_en SHALL be mutually exclusive in every cycle.
REQ-021 serial_in SHALL be 0 outside SHIFT.
REQ-022 data_valid outside READ SHALL be ignored.
REQ-023 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-024 arst_n low SHALL force, immediately and regardless of clk, the state IDLE, all counters to 0, and all outputs to 0 except req_ready=1.
REQ-025 A reset in the middle of an operation SHALL abort it with no response issued, and no strobe SHALL remain asserted.

Configuration
REQ-026 With SRAM_HOST_TIMEOUT_EN defined, a read cycle counter SHALL run in READ; if data_valid is not seen within TIMEOUT_CYC cycles, the block SHALL drop r_en, set rsp_data=0 and rsp_err=1, and go to RESP.
REQ-027 Without SRAM_HOST_TIMEOUT_EN, READ SHALL wait indefinitely, rsp_err SHALL be tied to 0, and no counter SHALL exist.

Structure
REQ-028 A shared package sram_pkg SHALL hold the default ROWS/COLS constants and the FSM state enum type sram_host_state_t.
REQ-029 The serializer SHALL be a sub-module sram_piso (COLS-bit shift register, MSB first, load/shift/done) instantiated once.

Verification
REQ-030 Write test (COLS=8): write addr 3, data 8'hA5 -> shift high 8 cycles with serial_in 1,0,1,0,0,1,0,1, then load 1 cycle, then w_en 1 cycle with addr=3, then rsp_valid at acceptance+11.
REQ-031 Write/read: write 8'h3C to addr 5, then read addr 5 with data_valid after 2 cycles -> rsp_data=8'h3C, rsp_err=0.
REQ-032 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable and req_ready stays 0.
REQ-033 Timeout (macro on, TIMEOUT_CYC=16): read with data_valid held 0 -> r_en drops after 16 cycles and the response has rsp_err=1, rsp_data=0.
REQ-034 Reset during SHIFT at bit 4 -> all strobes go to 0 asynchronously, state is IDLE, req_ready=1, and no rsp_valid occurs.
REQ-035 Random test: 1000 random reads and writes against a reference memory -> every read matches, and no two strobes are ever asserted together.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared defaults and FSM state type for the SRAM host controller slice.
package sram_pkg;

    localparam int SRAM_ROWS = 16;
    localparam int SRAM_COLS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LOAD,
        WRITE,
        READ,
        RESP
    } sram_host_state_t;

endpackage

// File: rtl/sram_piso.sv
// MSB-first parallel-in/serial-out shifter feeding the SRAM's serial write port.
// done flags the cycle in which the last bit is on serial_out.
module sram_piso
    import sram_pkg::*;
#(
    parameter int COLS = SRAM_COLS
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            load,
    input  logic            shift,
    input  logic [COLS-1:0] din,
    output logic            serial_out,
    output logic            done
);

    localparam int CW = $clog2(COLS) + 1;

    logic [COLS-1:0] sr;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= din;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr << 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign serial_out = sr[COLS-1];
    assign done       = shift && (cnt == CW'(COLS - 1));

endmodule

// File: rtl/sram_host_ctrl.sv
// Host request/response controller for a serial-write SRAM (shift, load, write; parallel read).
// Define SRAM_HOST_TIMEOUT_EN to bound the read wait and report expiry on rsp_err.
module sram_host_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS        = SRAM_ROWS,
    parameter int COLS        = SRAM_COLS,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [$clog2(ROWS)-1:0] req_addr,
    input  logic [COLS-1:0]         req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [COLS-1:0]         rsp_data,
    output logic                    rsp_err,
    output logic                    serial_in,
    output logic                    shift,
    output logic                    load,
    output logic                    w_en,
    output logic                    r_en,
    output logic [$clog2(ROWS)-1:0] addr,
    input  logic                    data_valid,
    input  logic [COLS-1:0]         data_out
);

    localparam int AW = $clog2(ROWS);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    sram_host_state_t state, state_nx;

    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [COLS-1:0] data_q;
    logic            accept;
    logic            rd_hit;
    logic            tmo_hit;
    logic            piso_load;
    logic            piso_out;
    logic            piso_done;

    assign accept    = req_valid && req_ready;
    assign rd_hit    = (state == READ) && data_valid && !we_q;
    assign piso_load = accept && req_we;

    sram_piso #(
        .COLS(COLS)
    ) u_piso (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (piso_load),
        .shift     (shift),
        .din       (req_wdata),
        .serial_out(piso_out),
        .done      (piso_done)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_we ? SHIFT : READ;
            SHIFT:   if (piso_done) state_nx = LOAD;
            LOAD:    state_nx = WRITE;
            WRITE:   state_nx = RESP;
            READ:    if (rd_hit || tmo_hit) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Response data is cleared on acceptance so writes and timeouts report zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            we_q   <= req_we;
            data_q <= '0;
        end else if (rd_hit) begin
            data_q <= data_out;
        end
    end

`ifdef SRAM_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == READ) && !rd_hit && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (tmo_hit) begin
            err_q   <= 1'b1;
        end else if (state == READ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Every strobe is a pure state decode, so reset clears them without waiting for clk.
    assign req_ready = (state == IDLE);
    assign shift     = (state == SHIFT);
    assign load      = (state == LOAD);
    assign w_en      = (state == WRITE);
    assign r_en      = (state == READ);
    assign rsp_valid = (state == RESP);
    assign serial_in = shift && piso_out;
    assign addr      = addr_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Self-checking bench for sram_host_ctrl: directed vector table, reset-abort sequence and
// random traffic against a reference memory (timeout vectors when SRAM_HOST_TIMEOUT_EN is set).
module tb_sram_host_ctrl;

    localparam int ROWS        = 16;
    localparam int COLS        = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int AW          = $clog2(ROWS);
`ifdef SRAM_HOST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [COLS-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [COLS-1:0] rsp_data;
    logic            rsp_err;
    logic            serial_in;
    logic            shift;
    logic            load;
    logic            w_en;
    logic            r_en;
    logic [AW-1:0]   addr;
    logic            data_valid = 1'b0;
    logic [COLS-1:0] data_out = '0;

    int checks   = 0;
    int failures = 0;

    logic [COLS-1:0] refMem  [ROWS] = '{default: '0};
    logic [COLS-1:0] sramMem [ROWS] = '{default: '0};
    logic [COLS-1:0] sipo  = '0;
    logic [COLS-1:0] latch = '0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   a;
        logic [COLS-1:0] wd;
        int              dvDelay;
        int              rdyDelay;
        logic [COLS-1:0] expData;
        logic            expErr;
    } vec_t;

    vec_t vecs[$];

    sram_host_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .serial_in (serial_in),
        .shift     (shift),
        .load      (load),
        .w_en      (w_en),
        .r_en      (r_en),
        .addr      (addr),
        .data_valid(data_valid),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // External SRAM model: SIPO, transfer latch, word array.
    always @(posedge clk) begin
        if (shift) sipo <= {sipo[COLS-2:0], serial_in};
        if (load)  latch <= sipo;
        if (w_en)  sramMem[addr] <= latch;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("strobes_exclusive", 32'($countones({shift, load, w_en, r_en}) <= 1), 1);
        if (!shift) checkOutput("serial_in_idle", serial_in, 0);
    end

    function automatic vec_t mkVec(input logic we, input int a, input int wd, input int dv,
                                   input int rdy, input int expData, input logic expErr);
        vec_t v;
        v.we = we; v.a = AW'(a); v.wd = COLS'(wd); v.dvDelay = dv; v.rdyDelay = rdy;
        v.expData = COLS'(expData); v.expErr = expErr;
        return v;
    endfunction

    // One full transaction, entered and left at a negedge; every cycle's strobes are checked.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] wd,
                                 input int dvDelay, input int rdyDelay,
                                 output logic [COLS-1:0] rdata, output logic rerr);
        int k;
        int expCyc;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = COLS'($urandom);
        if (we) begin
            for (int i = 1; i <= COLS; i++) begin
                checkOutput("shift_phase", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b100000);
                checkOutput("serial_bit", serial_in, wd[COLS-i]);
                data_valid = 1'($urandom); data_out = COLS'($urandom);
                @(negedge clk);
            end
            checkOutput("load_phase", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b010000);
            @(negedge clk);
            checkOutput("write_phase", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b001000);
            checkOutput("write_addr", addr, a);
            @(negedge clk);
        end else begin
            expCyc = dvDelay + 1;
            if (TMO_EN && expCyc > TIMEOUT_CYC) expCyc = TIMEOUT_CYC;
            k = 0;
            while (r_en && k < 300) begin
                k++;
                checkOutput("read_phase", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b000100);
                checkOutput("read_addr", addr, a);
                data_valid = (k == dvDelay + 1);
                data_out = data_valid ? sramMem[addr] : COLS'($urandom);
                @(negedge clk);
            end
            data_valid = 1'b0;
            checkOutput("r_en_cycles", k, expCyc);
        end
        checkOutput("resp_phase", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b000010);
        rdata = rsp_data;
        rerr  = rsp_err;
        for (int i = 0; i < rdyDelay; i++) begin
            data_valid = 1'($urandom); data_out = COLS'($urandom);
            @(negedge clk);
            checkOutput("resp_hold", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b000010);
            checkOutput("resp_data_stable", rsp_data, rdata);
            checkOutput("resp_err_stable", rsp_err, rerr);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0; data_valid = 1'b0;
        checkOutput("back_to_idle", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b000001);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [COLS-1:0] rdata;
        logic            rerr;
        logic            we;
        logic [AW-1:0]   a;
        logic [COLS-1:0] wd;
        int              dv;

        vecs.push_back(mkVec(1, 3,  'hA5, 0, 0, 'h00, 0));
        vecs.push_back(mkVec(1, 5,  'h3C, 0, 0, 'h00, 0));
        vecs.push_back(mkVec(0, 5,  0,    2, 0, 'h3C, 0));
        vecs.push_back(mkVec(0, 3,  0,    0, 0, 'hA5, 0));
        vecs.push_back(mkVec(0, 5,  0,    1, 5, 'h3C, 0));
        vecs.push_back(mkVec(1, 0,  'hFF, 0, 5, 'h00, 0));
        vecs.push_back(mkVec(1, 15, 'h01, 0, 1, 'h00, 0));
        vecs.push_back(mkVec(0, 15, 0,    3, 0, 'h01, 0));
        vecs.push_back(mkVec(0, 0,  0,    4, 2, 'hFF, 0));
`ifdef SRAM_HOST_TIMEOUT_EN
        vecs.push_back(mkVec(0, 5,  0,    1000, 2, 'h00, 1));
        vecs.push_back(mkVec(0, 5,  0,    TIMEOUT_CYC - 1, 0, 'h3C, 0));
        vecs.push_back(mkVec(0, 3,  0,    TIMEOUT_CYC, 0, 'h00, 1));
`endif

        #1;
        checkOutput("reset_ready", req_ready, 1);
        checkOutput("reset_strobes", {shift, load, w_en, r_en, rsp_valid, serial_in}, 0);
        checkOutput("reset_rsp", {rsp_data, rsp_err}, 0);
        checkOutput("reset_addr", addr, 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].dvDelay, vecs[i].rdyDelay, rdata, rerr);
            checkOutput($sformatf("vec%0d_data", i), rdata, vecs[i].expData);
            checkOutput($sformatf("vec%0d_err", i), rerr, vecs[i].expErr);
            if (vecs[i].we) refMem[vecs[i].a] = vecs[i].wd;
        end

        $display("[TB] reset during shift");
        req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(9); req_wdata = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid_shift_active", {shift, serial_in}, 2'b11);
        #2 arst_n = 1'b0;
        #1;
        checkOutput("rst_async_strobes", {shift, load, w_en, r_en, rsp_valid, serial_in}, 0);
        checkOutput("rst_async_ready", req_ready, 1);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < COLS + 4; i++) begin
            @(negedge clk);
            checkOutput("rst_no_response", {shift, load, w_en, r_en, rsp_valid, req_ready}, 6'b000001);
        end
        applyStimulus(1'b0, AW'(9), '0, 0, 0, rdata, rerr);
        checkOutput("rst_aborted_write", rdata, refMem[9]);

        $display("[TB] random traffic");
        for (int n = 0; n < 1000; n++) begin
            we = 1'($urandom);
            a  = AW'($urandom);
            wd = COLS'($urandom);
            dv = (TMO_EN && ($urandom_range(0, 9) == 0)) ? TIMEOUT_CYC + 3 : int'($urandom_range(0, 4));
            applyStimulus(we, a, wd, dv, int'($urandom_range(0, 2)), rdata, rerr);
            if (we) begin
                refMem[a] = wd;
                checkOutput("rand_write_rsp", {rdata, rerr}, 0);
            end else if (dv >= TIMEOUT_CYC) begin
                checkOutput("rand_timeout_rsp", {rdata, rerr}, {{COLS{1'b0}}, 1'b1});
            end else begin
                checkOutput("rand_read_data", rdata, refMem[a]);
                checkOutput("rand_read_err", rerr, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
